// File: rtl/nw_fill_controller_pkg.sv
// Shared definitions for the Needleman-Wunsch fill sequencer.
//   state_e    : controller state encoding
//   ScoreWidth : width of a stored matrix score (signed)
//   ScoreMin/ScoreMax : representable score range
//   sat9()     : clamps an integer score into the 9-bit signed range
package nw_fill_controller_pkg;

  localparam int ScoreWidth = 9;
  localparam int ScoreMin   = -256;
  localparam int ScoreMax   = 255;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StLoad,
    StRead,
    StWaitMax,
    StWrite,
    StNext,
    StDone
  } state_e;

  function automatic logic signed [ScoreWidth-1:0] sat9(input int value);
    int clamped;
    clamped = value;
    if (clamped < ScoreMin) clamped = ScoreMin;
    if (clamped > ScoreMax) clamped = ScoreMax;
    return ScoreWidth'(clamped);
  endfunction

endpackage

// File: rtl/nw_fill_controller_if.sv
// Handshake bundle between the fill sequencer and its neighbours
// (top-level FSM, score manager, max/compare unit).
//   master : the sequencer (drives enables, indices, busy/done)
//   slave  : the environment (drives start, hit, signal, max_valid)
interface nw_fill_controller_if #(
  parameter int unsigned BitAddr = 8
);
  import nw_fill_controller_pkg::*;

  logic                         start;
  logic                         hit;
  logic                         signal;
  logic                         max_valid;
  logic                         en_init;
  logic [BitAddr:0]             addr_init;
  logic signed [ScoreWidth-1:0] data_init;
  logic                         en_read;
  logic                         change_index;
  logic                         en_ins;
  logic                         we;
  logic [BitAddr:0]             i;
  logic [BitAddr:0]             j;
  logic                         busy;
  logic                         done;

  modport master (
    input  start, hit, signal, max_valid,
    output en_init, addr_init, data_init, en_read, change_index, en_ins, we, i, j, busy, done
  );

  modport slave (
    output start, hit, signal, max_valid,
    input  en_init, addr_init, data_init, en_read, change_index, en_ins, we, i, j, busy, done
  );

endinterface

// File: rtl/nw_fill_controller_walker.sv
// Index walker for the fill sequencer: owns boundary index k and cell
// coordinates i/j, all registered.
//   clk, rst   : clock, synchronous active-high reset (all indices to 0)
//   clear      : zero k, i, j at the start of a pass
//   k_inc      : step k to the next boundary pair
//   ij_load    : set i=j=1 (first fill cell)
//   ij_advance : row-major step; j wraps to 1 and i increments at the row end
//   k/i/j      : current indices
//   k_last/i_last/j_last : index equals N
module nw_fill_controller_walker #(
  parameter int unsigned N       = 128,
  parameter int unsigned BitAddr = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             k_inc,
  input  logic             ij_load,
  input  logic             ij_advance,
  output logic [BitAddr:0] k,
  output logic [BitAddr:0] i,
  output logic [BitAddr:0] j,
  output logic             k_last,
  output logic             i_last,
  output logic             j_last
);

  localparam int unsigned IdxW = BitAddr + 1;
  localparam logic [BitAddr:0] NIdx = IdxW'(N);
  localparam logic [BitAddr:0] One  = IdxW'(1);

  logic [BitAddr:0] k_q, i_q, j_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      k_q <= '0;
      i_q <= '0;
      j_q <= '0;
    end else begin
      if (k_inc) k_q <= k_q + One;
      if (ij_load) begin
        i_q <= One;
        j_q <= One;
      end else if (ij_advance) begin
        if (!j_last) begin
          j_q <= j_q + One;
        end else if (!i_last) begin
          j_q <= One;
          i_q <= i_q + One;
        end
      end
    end
  end

  assign k      = k_q;
  assign i      = i_q;
  assign j      = j_q;
  assign k_last = (k_q == NIdx);
  assign i_last = (i_q == NIdx);
  assign j_last = (j_q == NIdx);

endmodule

// File: rtl/nw_fill_controller.sv
// Sequencer for the Needleman-Wunsch score-matrix manager. After a start
// pulse it writes the row-0/column-0 gap boundary (each k as a row/column
// write pair), then fills cells (1,1)..(N,N) row-major: reload the read
// index, read the three neighbours, wait for the cell max, write it back.
//   clk, rst : clock, synchronous active-high reset
//   bus      : handshake bundle (master side), see nw_fill_controller_if
// All outputs are registered.
module nw_fill_controller
  import nw_fill_controller_pkg::*;
#(
  parameter int unsigned N       = 128,
  parameter int          GAP     = -2,
  parameter int unsigned BitAddr = $clog2(N + 1)
) (
  input logic                  clk,
  input logic                  rst,
  nw_fill_controller_if.master bus
);

  state_e                       state_q;
  logic                         en_init_q;
  logic signed [ScoreWidth-1:0] data_init_q;
  logic                         en_read_q;
  logic                         change_index_q;
  logic                         en_ins_q;
  logic                         we_q;
  logic                         busy_q;
  logic                         done_q;

  logic             walk_clear, k_inc, ij_load, ij_advance;
  logic             k_last, i_last, j_last, cell_last;
  logic [BitAddr:0] k, i, j;

  assign cell_last = i_last & j_last;

  always_comb begin
    walk_clear = (state_q == StIdle) & bus.start;
    k_inc      = (state_q == StInit) & bus.hit & ~k_last;
    ij_load    = (state_q == StInit) & bus.hit & k_last;
    ij_advance = (state_q == StNext) & ~cell_last;
  end

  nw_fill_controller_walker #(
    .N       (N),
    .BitAddr (BitAddr)
  ) u_walker (
    .clk        (clk),
    .rst        (rst),
    .clear      (walk_clear),
    .k_inc      (k_inc),
    .ij_load    (ij_load),
    .ij_advance (ij_advance),
    .k          (k),
    .i          (i),
    .j          (j),
    .k_last     (k_last),
    .i_last     (i_last),
    .j_last     (j_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      en_init_q      <= 1'b0;
      data_init_q    <= '0;
      en_read_q      <= 1'b0;
      change_index_q <= 1'b0;
      en_ins_q       <= 1'b0;
      we_q           <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      change_index_q <= 1'b0;
      done_q         <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q     <= StInit;
            busy_q      <= 1'b1;
            en_init_q   <= 1'b1;
            we_q        <= 1'b1;
            data_init_q <= '0;
          end
        end
        StInit: begin
          // hit marks the column half of a pair; the next k starts after it.
          if (bus.hit) begin
            if (k_last) begin
              state_q        <= StLoad;
              en_init_q      <= 1'b0;
              we_q           <= 1'b0;
              change_index_q <= 1'b1;
            end else begin
              data_init_q <= sat9((int'(k) + 1) * GAP);
            end
          end
        end
        StLoad: begin
          state_q   <= StRead;
          en_read_q <= 1'b1;
        end
        StRead: begin
          // The first READ cycle after NEXT carries change_index with
          // en_read low; signal only counts once reads are enabled.
          if (en_read_q && bus.signal) begin
            en_read_q <= 1'b0;
            if (bus.max_valid) begin
              state_q  <= StWrite;
              en_ins_q <= 1'b1;
              we_q     <= 1'b1;
            end else begin
              state_q <= StWaitMax;
            end
          end else begin
            en_read_q <= 1'b1;
          end
        end
        StWaitMax: begin
          if (bus.max_valid) begin
            state_q  <= StWrite;
            en_ins_q <= 1'b1;
            we_q     <= 1'b1;
          end
        end
        StWrite: begin
          state_q  <= StNext;
          en_ins_q <= 1'b0;
          we_q     <= 1'b0;
        end
        StNext: begin
          if (cell_last) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q        <= StRead;
            change_index_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          en_init_q <= 1'b0;
          en_read_q <= 1'b0;
          en_ins_q  <= 1'b0;
          we_q      <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.en_init      = en_init_q;
  assign bus.addr_init    = k;
  assign bus.data_init    = data_init_q;
  assign bus.en_read      = en_read_q;
  assign bus.change_index = change_index_q;
  assign bus.en_ins       = en_ins_q;
  assign bus.we           = we_q;
  assign bus.i            = i;
  assign bus.j            = j;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: doc/nw_fill_controller.md
Name: nw_fill_controller

Overview:
- Sequencer for the score-matrix manager of the Needleman-Wunsch engine.
- Runs two phases after a start pulse: initialisation of row 0 / column 0 with gap-penalty values, then a row-major fill of cells (1,1)..(N,N).
- For each fill cell it requests the three neighbour scores, waits for the cell max from the compute unit, and commits it.
- Sits between the top-level FSM (start/done) and the score manager plus the max/compare datapath.

Parameters:
- N, 128, sequence length; matrix is (N+1)x(N+1).
- BitAddr, $clog2(N+1), index width minus one; index ports are [BitAddr:0].
- GAP, -2, signed gap penalty per step used for boundary initialisation.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a full matrix pass; ignored unless in IDLE.
- hit  in  1  from score manager row/column write counter; 1 on the second (column) write of a boundary pair.
- signal  in  1  from score manager; 1 for one cycle when diag/up/left are valid.
- max_valid  in  1  from compute unit; cell max is valid on this cycle.
- en_init  out  1  boundary write enable.
- addr_init  out  BitAddr+1  boundary index k.
- data_init  out  9 signed  boundary value k*GAP.
- en_read  out  1  neighbour read enable.
- change_index  out  1  one-cycle pulse: read index generator reloads from i/j.
- en_ins  out  1  cell write select.
- we  out  1  RAM write strobe.
- i, j  out  BitAddr+1  current cell coordinates.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of pass.

Behaviour:
- All outputs are registered. Reset (at any time, including mid-pass) forces IDLE, all outputs to 0, i=j=0, k=0, and drops any pending handshake. No RAM writes occur in the reset cycle.
- States: IDLE, INIT, LOAD, READ, WAIT_MAX, WRITE, NEXT, DONE.
- IDLE: when start=1, go to INIT; k=0, busy=1 from the next cycle.
- INIT:
  - Drive en_init=1, we=1, addr_init=k, data_init=sat9(k*GAP). Each k is held two cycles: row write then column write.
  - When hit=1: if k==N, go to LOAD; else k+1.
  - sat9 clamps to [-256, 255]; with defaults, N*|GAP|=256 is exact at the minimum.
- LOAD: i=1, j=1, change_index=1 for one cycle, then READ.
- READ:
  - en_read=1 held until signal=1 (3-read latency of the manager).
  - On signal, drop en_read the next cycle and go to WAIT_MAX.
  - If signal and max_valid are both high in the same cycle, go directly to WRITE.
- WAIT_MAX: all enables 0; on max_valid=1 go to WRITE. There is no timeout.
- WRITE: en_ins=1, we=1 for exactly one cycle with i/j stable, then NEXT.
- NEXT:
  - If j<N: j+1.
  - Else if i<N: j=1, i+1.
  - Else go to DONE.
  - When advancing, pulse change_index for one cycle and go to READ.
- DONE: done=1 for one cycle, busy=0 next cycle, return to IDLE; i/j hold their last values until the next start.
- i/j never change in READ, WAIT_MAX or WRITE.
- en_init and en_ins are never both high. we is high only in INIT and WRITE.
- start during busy is ignored. max_valid outside WAIT_MAX/READ is ignored.
- Latency per cell, with immediate max_valid: 1 (change_index) + read latency + 1 (WRITE) + 1 (NEXT).

Decomposition:
- Shared package nw_pkg holds:
  - state encoding (localparam enum-style constants);
  - score width 9 and SCORE_MIN/SCORE_MAX (-256/255);
  - the saturation function sat9.
- One sub-module is natural: nw_index_walker. It owns i/j/k, increments and terminal flags (k_last, j_last, i_last), and takes advance/reload controls from the FSM.

Test Plan:
- Init sweep, N=4, GAP=-2, hit toggling each en_init cycle -> addr_init 0,0,1,1,...,4,4; data_init 0,0,-2,-2,...,-8,-8; en_init high for exactly 10 cycles, then LOAD with i=1, j=1.
- Fill order, N=3, signal 3 cycles after en_read rise, max_valid 2 cycles after signal -> 9 WRITE cycles with (i,j) = (1,1),(1,2),(1,3),(2,1)...(3,3); 9 change_index pulses; done exactly once after (3,3).
- Same-cycle signal and max_valid -> READ goes directly to WRITE; en_ins pulse width is 1 cycle.
- Saturation, N=128, GAP=-3 -> data_init at k=85 is -255; at k=86..128 it is -256.
- Reset asserted in WAIT_MAX at cell (2,2) -> next cycle all outputs 0 and busy=0; a new start restarts INIT at k=0.
- start pulsed while busy, plus max_valid pulsed during INIT -> no effect on sequence; total cycle count identical to an undisturbed run.
